// File: rtl/commit_pc_tap.sv
// commit_pc_tap: serialises dual-port retire commits into one in-order PC trace stream.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   trace_en          1 = capture commits, 0 = ignore commits while the FIFO keeps draining
//   commit_vld[1:0]   retire strobes, bit0 is the older instruction
//   commit_pc0/1      retired PCs for port 0 / port 1
//   piton_pc_vld      one-cycle pulse qualifying piton_pc
//   piton_pc          serialised committed PC, holds its value when idle
//   fifo_level        current FIFO occupancy
//   ovf_sticky        set on any dropped commit, cleared only by rst
//   drop_cnt          saturating count of dropped commits
//   loop_det          sticky self-loop flag
// Build option: define PC_TAP_LOOP_DETECT_EN to enable the self-loop detector;
// otherwise loop_det is tied low.
module commit_pc_tap #(
    parameter int DEPTH       = 8,
    parameter int PC_W        = 64,
    parameter int CNT_W       = 16,
    parameter int LOOP_THRESH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic [1:0]               commit_vld,
    input  logic [PC_W-1:0]          commit_pc0,
    input  logic [PC_W-1:0]          commit_pc1,
    output logic                     piton_pc_vld,
    output logic [PC_W-1:0]          piton_pc,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf_sticky,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     loop_det
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || LOOP_THRESH < 2) begin : g_bad_cfg
        $error("commit_pc_tap: DEPTH must be a power of two >= 4 and LOOP_THRESH >= 2");
    end

    logic [PC_W-1:0]  mem [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]    lvl_q, lvl_d, free;
    logic             vld_q, ovf_q, pop;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W:0]   drop_sum;
    logic [1:0]       cand, n_cand, n_acc, n_drop;

    // Free space comes from the registered level only, so a same-cycle pop never
    // makes room for a push; candidates are taken oldest-first while space remains.
    always_comb begin
        cand     = commit_vld & {2{trace_en}};
        free     = LW'(DEPTH) - lvl_q;
        n_cand   = {1'b0, cand[0]} + {1'b0, cand[1]};
        n_acc    = (free >= LW'(2)) ? n_cand : (free != '0 && n_cand != '0) ? 2'd1 : 2'd0;
        n_drop   = n_cand - n_acc;
        pop      = lvl_q != '0;
        lvl_d    = lvl_q + LW'(n_acc) - LW'(pop);
        wp_d     = wp_q + AW'(n_acc);
        rp_d     = rp_q + AW'(pop);
        drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(n_drop);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (n_acc != 2'd0) mem[wp_q] <= cand[0] ? commit_pc0 : commit_pc1;
        if (n_acc == 2'd2) mem[wp_q + AW'(1)] <= commit_pc1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            lvl_q  <= '0;
            vld_q  <= 1'b0;
            pc_q   <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            lvl_q  <= lvl_d;
            vld_q  <= pop;
            pc_q   <= pop ? mem[rp_q] : pc_q;
            ovf_q  <= ovf_q | (n_drop != 2'd0);
            drop_q <= drop_d;
        end
    end

`ifdef PC_TAP_LOOP_DETECT_EN
    localparam int CW = $clog2(LOOP_THRESH + 1);
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic          loop_q, same;

    // The popped head is compared against pc_q, which still holds the previously
    // emitted PC; a zero count marks "nothing emitted yet" so the first PC starts at 1.
    always_comb begin
        same   = (lcnt_q != '0) && (mem[rp_q] == pc_q);
        lcnt_d = !pop ? lcnt_q :
                 !same ? CW'(1) :
                 (lcnt_q == CW'(LOOP_THRESH)) ? lcnt_q : lcnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt_q <= '0;
            loop_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            loop_q <= loop_q | (lcnt_q == CW'(LOOP_THRESH));
        end
    end

    assign loop_det = loop_q;
`else
    assign loop_det = 1'b0;
`endif

    assign piton_pc_vld = vld_q;
    assign piton_pc     = pc_q;
    assign fifo_level   = lvl_q;
    assign ovf_sticky   = ovf_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_commit_pc_tap.sv
// tb_commit_pc_tap: queue-model checked bench for commit_pc_tap with directed and random commits.
module tb_commit_pc_tap;
    localparam int DEPTH = 8;
    localparam int THR   = 4;
    localparam int CNTW  = 4;
    localparam int MAXD  = 15;

    logic        clk, rst, trace_en;
    logic [1:0]  commit_vld;
    logic [63:0] commit_pc0, commit_pc1, piton_pc;
    logic        piton_pc_vld, ovf_sticky, loop_det;
    logic [3:0]  fifo_level;
    logic [3:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    commit_pc_tap #(.DEPTH(DEPTH), .PC_W(64), .CNT_W(CNTW), .LOOP_THRESH(THR)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .commit_vld(commit_vld),
        .commit_pc0(commit_pc0), .commit_pc1(commit_pc1),
        .piton_pc_vld(piton_pc_vld), .piton_pc(piton_pc), .fifo_level(fifo_level),
        .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt), .loop_det(loop_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of retired PCs plus counters.
    logic [63:0] q[$];
    logic [63:0] m_pc, m_h;
    bit          m_vld, m_ovf, m_loop;
    int          m_drop, m_run, m_free, m_nd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_vld = 0; m_pc = 0; m_drop = 0; m_ovf = 0; m_loop = 0; m_run = 0;
        end else begin
            m_free = DEPTH - q.size();
            m_nd   = 0;
            m_loop = m_loop || (m_run == THR);
            m_vld  = q.size() != 0;
            if (m_vld) begin
                m_h   = q.pop_front();
                m_run = (m_run != 0 && m_h == m_pc) ? ((m_run < THR) ? m_run + 1 : THR) : 1;
                m_pc  = m_h;
            end
            for (int p = 0; p < 2; p++) begin
                if (trace_en && commit_vld[p]) begin
                    if (m_free > 0) begin
                        q.push_back(p == 0 ? commit_pc0 : commit_pc1);
                        m_free--;
                    end else m_nd++;
                end
            end
            m_drop = (m_drop + m_nd > MAXD) ? MAXD : m_drop + m_nd;
            m_ovf  = m_ovf || (m_nd != 0);
        end
    end

    always @(negedge clk) begin
        chk("vld", piton_pc_vld, m_vld);
        chk("pc", piton_pc, m_pc);
        chk("level", fifo_level, q.size());
        chk("ovf", ovf_sticky, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
`ifdef PC_TAP_LOOP_DETECT_EN
        chk("loop_det", loop_det, m_loop);
`else
        chk("loop_det", loop_det, 0);
`endif
    end

    task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1, input logic en);
        commit_vld = v; commit_pc0 = p0; commit_pc1 = p1; trace_en = en;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, 64'h0, 64'h0, 1'b1);
    endtask

    int pulses;

    initial begin
        rst = 1'b1; trace_en = 1'b1; commit_vld = 2'b00; commit_pc0 = '0; commit_pc1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_vld", piton_pc_vld, 0);
        chk("rst_pc", piton_pc, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        idle(2);

        drive(2'b01, 64'h8000_0000, 64'h0, 1'b1);
        chk("single_level", fifo_level, 1);
        idle(1);
        chk("single_vld", piton_pc_vld, 1);
        chk("single_pc", piton_pc, 64'h8000_0000);
        chk("single_level0", fifo_level, 0);

        drive(2'b11, 64'h100, 64'h104, 1'b1);
        idle(1);
        chk("dual_pc0", piton_pc, 64'h100);
        idle(1);
        chk("dual_pc1", piton_pc, 64'h104);
        idle(1);
        chk("idle_vld", piton_pc_vld, 0);
        chk("idle_hold", piton_pc, 64'h104);
        chk("dual_nodrop", drop_cnt, 0);

        for (int k = 0; k < 10; k++) drive(2'b11, 64'(8 * k), 64'(8 * k + 4), 1'b1);
        chk("ovf_drop", drop_cnt, 4);
        chk("ovf_sticky", ovf_sticky, 1);
        chk("ovf_level", fifo_level, 7);
        idle(7);
        chk("ovf_last_pc", piton_pc, 64'h48);
        chk("ovf_drained", fifo_level, 0);

        drive(2'b11, 64'h300, 64'h304, 1'b1);
        drive(2'b11, 64'h308, 64'h30c, 1'b1);
        chk("pre_level", fifo_level, 3);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 64'h400 + 64'(k), 64'h500 + 64'(k), 1'b0);
            if (piton_pc_vld) pulses++;
        end
        chk("en0_pulses", pulses, 3);
        chk("en0_level", fifo_level, 0);
        chk("en0_drop", drop_cnt, 4);

        drive(2'b11, 64'h200, 64'h204, 1'b1);
        drive(2'b11, 64'h208, 64'h20c, 1'b1);
        drive(2'b11, 64'h210, 64'h214, 1'b1);
        drive(2'b11, 64'h218, 64'h21c, 1'b1);
        chk("pre_rst_level", fifo_level, 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", piton_pc_vld, 0);
        chk("arst_pc", piton_pc, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_ovf", ovf_sticky, 0);
        chk("arst_drop", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        chk("post_rst_vld", piton_pc_vld, 0);

        repeat (4) drive(2'b01, 64'h8000_1000, 64'h0, 1'b1);
        idle(1);
        chk("loop_4th_pulse", piton_pc_vld, 1);
        chk("loop_not_yet", loop_det, 0);
        idle(1);
`ifdef PC_TAP_LOOP_DETECT_EN
        chk("loop_set", loop_det, 1);
`else
        chk("loop_off", loop_det, 0);
`endif
        drive(2'b01, 64'h8000_2000, 64'h0, 1'b1);
        idle(2);
`ifdef PC_TAP_LOOP_DETECT_EN
        chk("loop_sticky", loop_det, 1);
`else
        chk("loop_off2", loop_det, 0);
`endif

        for (int k = 0; k < 400; k++)
            drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 7) != 0);
        for (int k = 0; k < 20; k++) drive(2'b11, 64'(k), 64'(k + 100), 1'b1);
        chk("drop_sat", drop_cnt, MAXD);
        idle(10);
        chk("final_level", fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
